// File: rtl/rtl_settings_pkg.sv
// Shared types for the Avalon-MM burst transmitter: data modes, FSM states,
// queued command layout, compare descriptor and the LFSR seed.
package rtl_settings_pkg;

  localparam int CMD_ADDR_W  = 32;
  localparam int CMD_LEN_W   = 12;
  localparam int CMP_ADDR_W  = 29;
  localparam int CMP_WORDS_W = 11;
  localparam int CMP_OFF_W   = 3;

  localparam logic [7:0] LFSR_SEED = 8'hFF;

  typedef enum logic [1:0] {
    MODE_FIXED = 2'd0,
    MODE_LFSR  = 2'd1,
    MODE_INCR  = 2'd2
  } data_mode_t;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_READ} tx_state_t;

  typedef enum logic {CMD_WRITE = 1'b0, CMD_READ = 1'b1} cmd_type_t;

  typedef struct packed {
    cmd_type_t              typ;
    logic [CMD_ADDR_W-1:0]  addr;
    logic [CMD_LEN_W-1:0]   bytes;
  } cmd_t;

  typedef struct packed {
    logic [CMP_ADDR_W-1:0]  addr;
    logic [CMP_WORDS_W-1:0] words;
    logic [CMP_OFF_W-1:0]   start_off;
    logic [CMP_OFF_W-1:0]   end_off;
    data_mode_t             mode;
    logic [7:0]             seed;
  } cmp_desc_t;

  // Encoding 3 is reserved and behaves as a fixed pattern.
  function automatic data_mode_t to_data_mode(input logic [1:0] m);
    return (m == 2'd3) ? MODE_FIXED : data_mode_t'(m);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered full/empty flags; push is refused while the
// registered full flag is set, even if a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_full;
  logic             r_empty;
  logic             w_push;
  logic             w_pop;
  logic [AW:0]      w_count_nxt;

  assign w_push    = push_i && !r_full;
  assign w_pop     = pop_i && !r_empty;
  assign full_o    = r_full;
  assign empty_o   = r_empty;
  assign pop_dat_o = r_mem[r_rd_ptr];

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)
      w_count_nxt = r_count + 1'b1;
    else if (!w_push && w_pop)
      w_count_nxt = r_count - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (w_push)
      r_mem[r_wr_ptr] <= push_dat_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == (AW + 1)'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

endmodule

// File: rtl/amm_burst_transmitter.sv
// Turns queued byte-addressed read/write commands into Avalon-MM bursts with
// generated write data, read-credit tracking and per-write compare descriptors.
module amm_burst_transmitter
  import rtl_settings_pkg::*;
#(
  parameter int ADDR_W      = CMD_ADDR_W,
  parameter int AMM_DATA_W  = 64,
  parameter int AMM_ADDR_W  = ADDR_W - $clog2(AMM_DATA_W / 8),
  parameter int AMM_BURST_W = CMP_WORDS_W,
  parameter int LEN_W       = AMM_BURST_W - 2 + $clog2(AMM_DATA_W / 8),
  parameter int CMD_DEPTH   = 4,
  parameter int MAX_RD_PEND = 256
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           cmd_valid_i,
  output logic                           cmd_ready_o,
  input  logic                           cmd_type_i,
  input  logic [ADDR_W-1:0]              cmd_addr_i,
  input  logic [LEN_W-1:0]               cmd_bytes_i,
  input  logic [1:0]                     data_mode_i,
  input  logic [7:0]                     data_ptrn_i,
  output logic                           busy_o,
  output logic [$clog2(MAX_RD_PEND+1)-1:0] rd_pend_o,
  output logic                           cmp_valid_o,
  output logic [AMM_ADDR_W-1:0]          cmp_addr_o,
  output logic [AMM_BURST_W-1:0]         cmp_words_o,
  output logic [$clog2(AMM_DATA_W/8)-1:0] cmp_start_off_o,
  output logic [$clog2(AMM_DATA_W/8)-1:0] cmp_end_off_o,
  output logic [1:0]                     cmp_mode_o,
  output logic [7:0]                     cmp_seed_o,
  output logic [AMM_ADDR_W-1:0]          address_o,
  output logic                           read_o,
  output logic                           write_o,
  output logic [AMM_DATA_W-1:0]          writedata_o,
  output logic [AMM_BURST_W-1:0]         burstcount_o,
  output logic [AMM_DATA_W/8-1:0]        byteenable_o,
  input  logic                           waitrequest_i,
  input  logic                           readdatavalid_i,
  input  logic [AMM_DATA_W-1:0]          readdata_i
);

  localparam int DATA_B   = AMM_DATA_W / 8;
  localparam int ADDR_B_W = $clog2(DATA_B);
  localparam int RDW      = $clog2(MAX_RD_PEND + 1);

  function automatic logic [DATA_B-1:0] be_range(input logic [ADDR_B_W-1:0] lo,
                                                 input logic [ADDR_B_W-1:0] hi);
    logic [DATA_B-1:0] be;
    for (int i = 0; i < DATA_B; i++)
      be[i] = (i >= int'(lo)) && (i <= int'(hi));
    return be;
  endfunction

  function automatic logic [AMM_DATA_W-1:0] gen_beat(input data_mode_t mode,
                                                     input logic [7:0] ptrn,
                                                     input logic [7:0] lfsr,
                                                     input logic [AMM_BURST_W-1:0] k);
    logic [AMM_DATA_W-1:0] d;
    d = '0;
    for (int i = 0; i < DATA_B; i++) begin
      case (mode)
        MODE_LFSR: d[8*i +: 8] = lfsr;
        MODE_INCR: d[8*i +: 8] = ptrn + 8'(k * DATA_B) + 8'(i);
        default:   d[8*i +: 8] = ptrn;
      endcase
    end
    return d;
  endfunction

  cmd_t                  w_push_cmd;
  cmd_t                  w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic [ADDR_B_W-1:0]   w_start_off;
  logic [ADDR_B_W-1:0]   w_end_off;
  logic [LEN_W:0]        w_sum;
  logic [AMM_BURST_W-1:0] w_words;
  logic                  w_rd_stall;
  data_mode_t            w_mode_in;
  tx_state_t             r_state;
  tx_state_t             w_state_nxt;
  logic                  w_load_wr;
  logic                  w_load_rd;
  logic                  w_beat_acc;
  logic                  w_last_acc;
  logic                  w_rd_acc;
  logic [AMM_BURST_W-1:0] r_beat;
  logic [AMM_BURST_W-1:0] w_next_beat;
  logic                  w_next_last;
  logic [7:0]            r_lfsr;
  logic [7:0]            w_lfsr_nxt;
  data_mode_t            r_mode;
  logic [7:0]            r_ptrn;
  logic [ADDR_B_W-1:0]   r_end_off;
  logic [RDW-1:0]        r_rd_pend;
  logic [RDW-1:0]        w_rd_pend_nxt;
  cmp_desc_t             r_cmp;
  logic                  w_unused_rdata;

  assign w_push_cmd = '{typ: cmd_type_t'(cmd_type_i), addr: cmd_addr_i, bytes: cmd_bytes_i};

  sync_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .push_i    (cmd_valid_i),
    .push_dat_i(w_push_cmd),
    .full_o    (w_full),
    .pop_i     (w_pop),
    .pop_dat_o (w_head),
    .empty_o   (w_empty)
  );

  assign w_start_off = w_head.addr[ADDR_B_W-1:0];
  assign w_sum       = {1'b0, w_head.bytes} + (LEN_W + 1)'(w_start_off);
  assign w_words     = AMM_BURST_W'(w_sum[LEN_W:ADDR_B_W]) + 1'b1;
  assign w_end_off   = w_sum[ADDR_B_W-1:0];
  assign w_rd_stall  = (32'(r_rd_pend) + 32'(w_words)) > 32'(MAX_RD_PEND);
  assign w_mode_in   = to_data_mode(data_mode_i);
  assign w_next_beat = r_beat + 1'b1;
  assign w_next_last = (w_next_beat == burstcount_o - 1'b1);
  assign w_lfsr_nxt  = {r_lfsr[6:0], r_lfsr[6] ^ r_lfsr[1] ^ r_lfsr[0]};
  assign w_unused_rdata = ^readdata_i;

  assign cmd_ready_o     = !w_full;
  assign busy_o          = !w_empty || (r_state != S_IDLE) || (r_rd_pend != '0);
  assign rd_pend_o       = r_rd_pend;
  assign cmp_addr_o      = r_cmp.addr;
  assign cmp_words_o     = r_cmp.words;
  assign cmp_start_off_o = r_cmp.start_off;
  assign cmp_end_off_o   = r_cmp.end_off;
  assign cmp_mode_o      = r_cmp.mode;
  assign cmp_seed_o      = r_cmp.seed;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load_wr   = 1'b0;
    w_load_rd   = 1'b0;
    w_beat_acc  = 1'b0;
    w_last_acc  = 1'b0;
    w_rd_acc    = 1'b0;
    case (r_state)
      S_IDLE: if (!w_empty) w_state_nxt = S_LOAD;
      S_LOAD: begin
        if (w_head.typ == CMD_WRITE) begin
          w_pop       = 1'b1;
          w_load_wr   = 1'b1;
          w_state_nxt = S_WRITE;
        end else if (!w_rd_stall) begin
          w_pop       = 1'b1;
          w_load_rd   = 1'b1;
          w_state_nxt = S_READ;
        end
      end
      S_WRITE: if (!waitrequest_i) begin
        w_beat_acc = 1'b1;
        if (r_beat == burstcount_o - 1'b1) begin
          w_last_acc  = 1'b1;
          w_state_nxt = w_empty ? S_IDLE : S_LOAD;
        end
      end
      S_READ: if (!waitrequest_i) begin
        w_rd_acc    = 1'b1;
        w_state_nxt = w_empty ? S_IDLE : S_LOAD;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A read data beat with nothing outstanding is dropped rather than wrapping.
  always_comb begin
    w_rd_pend_nxt = r_rd_pend;
    if (w_rd_acc)
      w_rd_pend_nxt = w_rd_pend_nxt + RDW'(burstcount_o);
    if (readdatavalid_i && (r_rd_pend != '0))
      w_rd_pend_nxt = w_rd_pend_nxt - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      address_o    <= '0;
      writedata_o  <= '0;
      burstcount_o <= '0;
      byteenable_o <= '0;
      read_o       <= 1'b0;
      write_o      <= 1'b0;
      cmp_valid_o  <= 1'b0;
      r_cmp        <= '0;
      r_lfsr       <= LFSR_SEED;
      r_mode       <= MODE_FIXED;
      r_ptrn       <= '0;
      r_end_off    <= '0;
      r_beat       <= '0;
      r_rd_pend    <= '0;
    end else begin
      cmp_valid_o <= 1'b0;
      r_rd_pend   <= w_rd_pend_nxt;
      if (w_load_wr) begin
        address_o    <= w_head.addr[ADDR_W-1:ADDR_B_W];
        burstcount_o <= w_words;
        byteenable_o <= be_range(w_start_off,
                                 (w_words == 1) ? w_end_off : ADDR_B_W'(DATA_B - 1));
        writedata_o  <= gen_beat(w_mode_in, data_ptrn_i, r_lfsr, '0);
        if (w_mode_in == MODE_LFSR)
          r_lfsr <= w_lfsr_nxt;
        r_mode      <= w_mode_in;
        r_ptrn      <= data_ptrn_i;
        r_end_off   <= w_end_off;
        r_beat      <= '0;
        write_o     <= 1'b1;
        cmp_valid_o <= 1'b1;
        r_cmp       <= '{addr: w_head.addr[ADDR_W-1:ADDR_B_W], words: w_words,
                         start_off: w_start_off, end_off: w_end_off, mode: w_mode_in,
                         seed: (w_mode_in == MODE_LFSR) ? r_lfsr : data_ptrn_i};
      end
      if (w_load_rd) begin
        address_o    <= w_head.addr[ADDR_W-1:ADDR_B_W];
        burstcount_o <= w_words;
        byteenable_o <= '1;
        read_o       <= 1'b1;
      end
      if (w_beat_acc) begin
        if (w_last_acc) begin
          write_o <= 1'b0;
        end else begin
          r_beat       <= w_next_beat;
          writedata_o  <= gen_beat(r_mode, r_ptrn, r_lfsr, w_next_beat);
          byteenable_o <= w_next_last ? be_range('0, r_end_off) : '1;
          if (r_mode == MODE_LFSR)
            r_lfsr <= w_lfsr_nxt;
        end
      end
      if (w_rd_acc)
        read_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_amm_burst_transmitter.sv
// Directed bench with write/read/compare scoreboards for amm_burst_transmitter.
module tb_amm_burst_transmitter;

  typedef struct {
    logic [28:0] addr;
    logic [10:0] bc;
    logic [63:0] data;
    logic [7:0]  be;
  } beat_t;

  typedef struct {
    logic [28:0] addr;
    logic [10:0] words;
    logic [2:0]  so;
    logic [2:0]  eo;
    logic [1:0]  mode;
    logic [7:0]  seed;
  } cmp_exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_type;
  logic [31:0] cmd_addr;
  logic [11:0] cmd_bytes;
  logic [1:0]  data_mode;
  logic [7:0]  data_ptrn;
  logic        waitreq, rdv;
  logic [63:0] readdata;
  logic        cmd_ready_o, busy_o, cmp_valid_o, read_o, write_o;
  logic [3:0]  rd_pend_o;
  logic [28:0] cmp_addr_o, address_o;
  logic [10:0] cmp_words_o, burstcount_o;
  logic [2:0]  cmp_start_off_o, cmp_end_off_o;
  logic [1:0]  cmp_mode_o;
  logic [7:0]  cmp_seed_o, byteenable_o;
  logic [63:0] writedata_o;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] m_lfsr = 8'hFF;
  beat_t    wdq[$];
  beat_t    rdq[$];
  cmp_exp_t cmpq[$];

  always #5 clk = ~clk;

  amm_burst_transmitter #(.CMD_DEPTH(4), .MAX_RD_PEND(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o),
    .cmd_type_i(cmd_type), .cmd_addr_i(cmd_addr), .cmd_bytes_i(cmd_bytes),
    .data_mode_i(data_mode), .data_ptrn_i(data_ptrn), .busy_o(busy_o), .rd_pend_o(rd_pend_o),
    .cmp_valid_o(cmp_valid_o), .cmp_addr_o(cmp_addr_o), .cmp_words_o(cmp_words_o),
    .cmp_start_off_o(cmp_start_off_o), .cmp_end_off_o(cmp_end_off_o), .cmp_mode_o(cmp_mode_o),
    .cmp_seed_o(cmp_seed_o), .address_o(address_o), .read_o(read_o), .write_o(write_o),
    .writedata_o(writedata_o), .burstcount_o(burstcount_o), .byteenable_o(byteenable_o),
    .waitrequest_i(waitreq), .readdatavalid_i(rdv), .readdata_i(readdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input logic [31:0] addr, input int bytes, input int max_beats);
    int so, sum, words, eo;
    cmp_exp_t c;
    beat_t b;
    so    = int'(addr[2:0]);
    sum   = so + bytes;
    words = sum / 8 + 1;
    eo    = sum % 8;
    c.addr = addr[31:3]; c.words = 11'(words); c.so = 3'(so); c.eo = 3'(eo);
    c.mode = data_mode; c.seed = (data_mode == 2'd1) ? m_lfsr : data_ptrn;
    cmpq.push_back(c);
    for (int k = 0; k < words; k++) begin
      b.addr = addr[31:3];
      b.bc   = 11'(words);
      for (int i = 0; i < 8; i++) begin
        b.be[i] = (k > 0 || i >= so) && (k < words - 1 || i <= eo);
        case (data_mode)
          2'd1:    b.data[8*i +: 8] = m_lfsr;
          2'd2:    b.data[8*i +: 8] = 8'((int'(data_ptrn) + k * 8 + i) % 256);
          default: b.data[8*i +: 8] = data_ptrn;
        endcase
      end
      if (k < max_beats) wdq.push_back(b);
      if (data_mode == 2'd1) m_lfsr = {m_lfsr[6:0], m_lfsr[6] ^ m_lfsr[1] ^ m_lfsr[0]};
    end
  endtask

  task automatic expect_read(input logic [31:0] addr, input int bytes);
    beat_t b;
    b.addr = addr[31:3];
    b.bc   = 11'((int'(addr[2:0]) + bytes) / 8 + 1);
    b.data = '0;
    b.be   = 8'hFF;
    rdq.push_back(b);
  endtask

  task automatic send_cmd(input logic typ, input logic [31:0] addr, input logic [11:0] bytes);
    int t = 0;
    while (!cmd_ready_o && t < 200) begin tick(); t++; end
    chk("cmd_ready_wait", cmd_ready_o, 1'b1);
    cmd_valid = 1'b1; cmd_type = typ; cmd_addr = addr; cmd_bytes = bytes;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (busy_o && t < 500) begin tick(); t++; end
    chk(tag, busy_o, 1'b0);
  endtask

  task automatic wait_write(input string tag);
    int t = 0;
    while (!write_o && t < 50) begin tick(); t++; end
    chk(tag, write_o, 1'b1);
  endtask

  always @(negedge clk) begin
    beat_t b;
    cmp_exp_t c;
    if (rst_n && write_o && !waitreq) begin
      chk("wr_beat_expected", wdq.size() > 0, 1'b1);
      if (wdq.size() > 0) begin
        b = wdq.pop_front();
        chk("wr_address", address_o, b.addr);
        chk("wr_burstcount", burstcount_o, b.bc);
        chk("wr_data", writedata_o, b.data);
        chk("wr_byteenable", byteenable_o, b.be);
      end
    end
    if (rst_n && read_o && !waitreq) begin
      chk("rd_expected", rdq.size() > 0, 1'b1);
      if (rdq.size() > 0) begin
        b = rdq.pop_front();
        chk("rd_address", address_o, b.addr);
        chk("rd_burstcount", burstcount_o, b.bc);
        chk("rd_byteenable", byteenable_o, b.be);
      end
    end
    if (rst_n && cmp_valid_o) begin
      chk("cmp_expected", cmpq.size() > 0, 1'b1);
      if (cmpq.size() > 0) begin
        c = cmpq.pop_front();
        chk("cmp_addr", cmp_addr_o, c.addr);
        chk("cmp_words", cmp_words_o, c.words);
        chk("cmp_start_off", cmp_start_off_o, c.so);
        chk("cmp_end_off", cmp_end_off_o, c.eo);
        chk("cmp_mode", cmp_mode_o, c.mode);
        chk("cmp_seed", cmp_seed_o, c.seed);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_type = 1'b0; cmd_addr = '0; cmd_bytes = '0;
    data_mode = 2'd0; data_ptrn = 8'h00; waitreq = 1'b0; rdv = 1'b0; readdata = '0;
    repeat (3) tick();
    chk("rst_write", write_o, 1'b0);
    chk("rst_read", read_o, 1'b0);
    chk("rst_cmp_valid", cmp_valid_o, 1'b0);
    chk("rst_rd_pend", rd_pend_o, 4'd0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_cmd_ready", cmd_ready_o, 1'b1);
    chk("rst_address", address_o, 29'd0);
    chk("rst_writedata", writedata_o, 64'd0);
    chk("rst_burstcount", burstcount_o, 11'd0);
    chk("rst_byteenable", byteenable_o, 8'd0);
    chk("rst_cmp_seed", cmp_seed_o, 8'd0);
    rst_n = 1'b1;
    tick();

    // Unaligned two-beat fixed-pattern write
    data_mode = 2'd0; data_ptrn = 8'hA5;
    expect_write(32'h13, 12, 16);
    send_cmd(1'b0, 32'h13, 12'h00C);
    wait_idle("t1_idle");

    // Incrementing data with a two-cycle stall on beat 1
    data_mode = 2'd2; data_ptrn = 8'hFE;
    expect_write(32'h40, 23, 16);
    send_cmd(1'b0, 32'h40, 12'd23);
    wait_write("t2_write_start");
    chk("t2_beat0", writedata_o, 64'h0504030201_00FFFE);
    tick();
    waitreq = 1'b1;
    tick();
    chk("t2_hold1", writedata_o, 64'h0D0C0B0A09080706);
    chk("t2_write_held", write_o, 1'b1);
    tick();
    chk("t2_hold2", writedata_o, 64'h0D0C0B0A09080706);
    waitreq = 1'b0;
    wait_idle("t2_idle");

    // Back-to-back single-word LFSR writes
    data_mode = 2'd1; data_ptrn = 8'h00;
    expect_write(32'h100, 3, 16);
    expect_write(32'h108, 7, 16);
    send_cmd(1'b0, 32'h100, 12'd3);
    send_cmd(1'b0, 32'h108, 12'd7);
    wait_idle("t3_idle");

    // Read credit limit of 8 words
    expect_read(32'h200, 31);
    expect_read(32'h300, 31);
    expect_read(32'h400, 15);
    send_cmd(1'b1, 32'h200, 12'd31);
    send_cmd(1'b1, 32'h300, 12'd31);
    send_cmd(1'b1, 32'h400, 12'd15);
    repeat (12) tick();
    chk("t4_pend_full", rd_pend_o, 4'd8);
    chk("t4_stalled_read", read_o, 1'b0);
    chk("t4_third_pending", rdq.size(), 64'd1);
    rdv = 1'b1; tick(); rdv = 1'b0;
    repeat (3) tick();
    chk("t4_pend_7", rd_pend_o, 4'd7);
    chk("t4_still_stalled", rdq.size(), 64'd1);
    rdv = 1'b1; tick(); rdv = 1'b0;
    repeat (4) tick();
    chk("t4_pend_after_issue", rd_pend_o, 4'd8);
    chk("t4_third_issued", rdq.size(), 64'd0);
    rdv = 1'b1; repeat (9) tick(); rdv = 1'b0;
    chk("t4_pend_saturate", rd_pend_o, 4'd0);
    tick();
    chk("t4_busy_clear", busy_o, 1'b0);

    // Queue fill while the slave stalls
    waitreq = 1'b1; data_mode = 2'd0; data_ptrn = 8'h5A;
    for (int n = 0; n < 5; n++) begin
      expect_write(32'h500 + 32'(16 * n), 7, 16);
      send_cmd(1'b0, 32'h500 + 32'(16 * n), 12'd7);
    end
    chk("t5_ready_low", cmd_ready_o, 1'b0);
    tick();
    chk("t5_ready_still_low", cmd_ready_o, 1'b0);
    chk("t5_write_waiting", write_o, 1'b1);
    waitreq = 1'b0;
    wait_idle("t5_idle");

    // Reset in the middle of a four-beat write with a read outstanding
    data_mode = 2'd0; data_ptrn = 8'h3C;
    expect_read(32'h700, 15);
    send_cmd(1'b1, 32'h700, 12'd15);
    expect_write(32'h600, 31, 2);
    send_cmd(1'b0, 32'h600, 12'd31);
    wait_write("t6_write_start");
    tick();
    tick();
    chk("t6_pend_before_rst", rd_pend_o, 4'd2);
    rst_n = 1'b0;
    tick();
    chk("t6_rst_write", write_o, 1'b0);
    chk("t6_rst_rd_pend", rd_pend_o, 4'd0);
    chk("t6_rst_busy", busy_o, 1'b0);
    chk("t6_rst_ready", cmd_ready_o, 1'b1);
    m_lfsr = 8'hFF;
    rst_n = 1'b1;
    tick();
    expect_write(32'h680, 9, 16);
    send_cmd(1'b0, 32'h680, 12'd9);
    wait_idle("t6_idle");
    tick();

    chk("end_wr_queue", wdq.size(), 64'd0);
    chk("end_rd_queue", rdq.size(), 64'd0);
    chk("end_cmp_queue", cmpq.size(), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
